// File: rtl/logic_rs_pkg.sv
// Shared definitions for the logic-unit reservation station: op codes, entry states, tag constants.
package logic_rs_pkg;
  localparam int TAG_W_DEF = 4;
  localparam int TAG_NONE  = 0;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } rs_state_t;
endpackage

// File: rtl/logic_rs_entry.sv
// One reservation-station entry: holds op/operands, snoops the CDB, becomes READY when both tags clear.
// Issue with CDB bypass and wakeup both take effect at the edge; dispatch frees the entry at the edge.
module logic_rs_entry
  import logic_rs_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_alloc,
  input  logic [1:0]       i_op,
  input  logic [TAG_W-1:0] i_qj,
  input  logic [TAG_W-1:0] i_qk,
  input  logic [31:0]      i_vj,
  input  logic [31:0]      i_vk,
  input  logic             i_cdb_vld,
  input  logic [TAG_W-1:0] i_cdb_tag,
  input  logic [31:0]      i_cdb_dat,
  input  logic             i_disp,
  output rs_state_t        o_state,
  output logic [1:0]       o_op,
  output logic [31:0]      o_vj,
  output logic [31:0]      o_vk
);
  localparam logic [TAG_W-1:0] TAG_Z = TAG_W'(TAG_NONE);

  rs_state_t        r_state, w_nxt_state;
  logic [1:0]       r_op, w_nxt_op;
  logic [TAG_W-1:0] r_qj, r_qk, w_nxt_qj, w_nxt_qk;
  logic [31:0]      r_vj, r_vk, w_nxt_vj, w_nxt_vk;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_op    = r_op;
    w_nxt_qj    = r_qj;
    w_nxt_qk    = r_qk;
    w_nxt_vj    = r_vj;
    w_nxt_vk    = r_vk;
    case (r_state)
      ST_FREE: begin
        if (i_alloc) begin
          w_nxt_op = i_op;
          // Same-cycle bypass: a producer broadcasting now will not broadcast again.
          if (i_cdb_vld && (i_qj != TAG_Z) && (i_qj == i_cdb_tag)) begin
            w_nxt_qj = TAG_Z;
            w_nxt_vj = i_cdb_dat;
          end else begin
            w_nxt_qj = i_qj;
            w_nxt_vj = i_vj;
          end
          if (i_cdb_vld && (i_qk != TAG_Z) && (i_qk == i_cdb_tag)) begin
            w_nxt_qk = TAG_Z;
            w_nxt_vk = i_cdb_dat;
          end else begin
            w_nxt_qk = i_qk;
            w_nxt_vk = i_vk;
          end
          w_nxt_state = ((w_nxt_qj == TAG_Z) && (w_nxt_qk == TAG_Z)) ? ST_READY : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_cdb_vld && (r_qj != TAG_Z) && (r_qj == i_cdb_tag)) begin
          w_nxt_qj = TAG_Z;
          w_nxt_vj = i_cdb_dat;
        end
        if (i_cdb_vld && (r_qk != TAG_Z) && (r_qk == i_cdb_tag)) begin
          w_nxt_qk = TAG_Z;
          w_nxt_vk = i_cdb_dat;
        end
        w_nxt_state = ((w_nxt_qj == TAG_Z) && (w_nxt_qk == TAG_Z)) ? ST_READY : ST_WAIT;
      end
      ST_READY: begin
        if (i_disp) w_nxt_state = ST_FREE;
      end
      default: w_nxt_state = ST_FREE;
    endcase
    if (i_flush) w_nxt_state = ST_FREE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_FREE;
      r_op    <= '0;
      r_qj    <= '0;
      r_qk    <= '0;
      r_vj    <= '0;
      r_vk    <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_op    <= w_nxt_op;
      r_qj    <= w_nxt_qj;
      r_qk    <= w_nxt_qk;
      r_vj    <= w_nxt_vj;
      r_vk    <= w_nxt_vk;
    end
  end

  assign o_state = r_state;
  assign o_op    = r_op;
  assign o_vj    = r_vj;
  assign o_vk    = r_vk;
endmodule

// File: rtl/logic_rs.sv
// Reservation station for the logic unit: DEPTH entries, lowest-free allocation, lowest-ready dispatch.
// ISSUE_READY/ISSUE_TAG come from registered state only; DISP_* hold while DISP_READY is low.
module logic_rs
  import logic_rs_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int RS_BASE = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             ISSUE_VALID,
  output logic             ISSUE_READY,
  input  logic [1:0]       ISSUE_OP,
  input  logic [TAG_W-1:0] ISSUE_QJ,
  input  logic [TAG_W-1:0] ISSUE_QK,
  input  logic [31:0]      ISSUE_VJ,
  input  logic [31:0]      ISSUE_VK,
  output logic [TAG_W-1:0] ISSUE_TAG,
  input  logic             CDB_VALID,
  input  logic [TAG_W-1:0] CDB_TAG,
  input  logic [31:0]      CDB_DATA,
  output logic             DISP_VALID,
  input  logic             DISP_READY,
  output logic [1:0]       DISP_OP,
  output logic [31:0]      DISP_A,
  output logic [31:0]      DISP_B,
  output logic [TAG_W-1:0] DISP_TAG
);
  localparam int IDX_W = $clog2(DEPTH);

  rs_state_t        w_state [DEPTH];
  logic [1:0]       w_op    [DEPTH];
  logic [31:0]      w_vj    [DEPTH];
  logic [31:0]      w_vk    [DEPTH];
  logic [DEPTH-1:0] w_alloc, w_disp;
  logic             w_free_found, w_rdy_found;
  logic [IDX_W-1:0] w_free_idx, w_rdy_idx;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_rdy_found  = 1'b0;
    w_rdy_idx    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_state[i] == ST_FREE) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
      if (w_state[i] == ST_READY) begin
        w_rdy_found = 1'b1;
        w_rdy_idx   = IDX_W'(i);
      end
    end
    w_alloc = '0;
    w_disp  = '0;
    if (ISSUE_VALID && w_free_found) w_alloc[w_free_idx] = 1'b1;
    if (DISP_READY && w_rdy_found)   w_disp[w_rdy_idx]   = 1'b1;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic_rs_entry #(.TAG_W(TAG_W)) u_ent (
      .i_clk     (CLK),
      .i_rst     (RST),
      .i_flush   (FLUSH),
      .i_alloc   (w_alloc[g]),
      .i_op      (ISSUE_OP),
      .i_qj      (ISSUE_QJ),
      .i_qk      (ISSUE_QK),
      .i_vj      (ISSUE_VJ),
      .i_vk      (ISSUE_VK),
      .i_cdb_vld (CDB_VALID),
      .i_cdb_tag (CDB_TAG),
      .i_cdb_dat (CDB_DATA),
      .i_disp    (w_disp[g]),
      .o_state   (w_state[g]),
      .o_op      (w_op[g]),
      .o_vj      (w_vj[g]),
      .o_vk      (w_vk[g])
    );
  end

  assign ISSUE_READY = w_free_found;
  assign ISSUE_TAG   = TAG_W'(RS_BASE) + TAG_W'(w_free_idx);
  assign DISP_VALID  = w_rdy_found;
  assign DISP_OP     = w_rdy_found ? w_op[w_rdy_idx] : 2'b00;
  assign DISP_A      = w_rdy_found ? w_vj[w_rdy_idx] : 32'h0;
  assign DISP_B      = w_rdy_found ? w_vk[w_rdy_idx] : 32'h0;
  assign DISP_TAG    = TAG_W'(RS_BASE) + TAG_W'(w_rdy_idx);
endmodule

// File: tb/tb_logic_rs.sv
// Bench for logic_rs: directed scenarios then random traffic against a slot-list reference model.
module tb_logic_rs;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int RS_BASE = 1;

  logic             CLK = 1'b0;
  logic             RST, FLUSH, ISSUE_VALID, ISSUE_READY;
  logic [1:0]       ISSUE_OP;
  logic [TAG_W-1:0] ISSUE_QJ, ISSUE_QK, ISSUE_TAG;
  logic [31:0]      ISSUE_VJ, ISSUE_VK;
  logic             CDB_VALID;
  logic [TAG_W-1:0] CDB_TAG;
  logic [31:0]      CDB_DATA;
  logic             DISP_VALID, DISP_READY;
  logic [1:0]       DISP_OP;
  logic [31:0]      DISP_A, DISP_B;
  logic [TAG_W-1:0] DISP_TAG;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: occupied slots with pending producer tags; a slot is dispatchable when it waits on nothing.
  bit         m_busy [DEPTH];
  logic [1:0] m_op   [DEPTH];
  int         m_qj   [DEPTH];
  int         m_qk   [DEPTH];
  logic [31:0] m_vj  [DEPTH];
  logic [31:0] m_vk  [DEPTH];

  logic_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W), .RS_BASE(RS_BASE)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_READY(ISSUE_READY), .ISSUE_OP(ISSUE_OP),
    .ISSUE_QJ(ISSUE_QJ), .ISSUE_QK(ISSUE_QK), .ISSUE_VJ(ISSUE_VJ), .ISSUE_VK(ISSUE_VK),
    .ISSUE_TAG(ISSUE_TAG), .CDB_VALID(CDB_VALID), .CDB_TAG(CDB_TAG), .CDB_DATA(CDB_DATA),
    .DISP_VALID(DISP_VALID), .DISP_READY(DISP_READY), .DISP_OP(DISP_OP),
    .DISP_A(DISP_A), .DISP_B(DISP_B), .DISP_TAG(DISP_TAG)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int first_ready();
    for (int i = 0; i < DEPTH; i++)
      if (m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0) return i;
    return -1;
  endfunction

  function automatic int first_free();
    for (int i = 0; i < DEPTH; i++)
      if (!m_busy[i]) return i;
    return -1;
  endfunction

  task automatic model_update();
    int di, fi, qj, qk;
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_busy[i] = 0; m_op[i] = 0; m_qj[i] = 0; m_qk[i] = 0; m_vj[i] = 0; m_vk[i] = 0;
      end
    end else if (FLUSH) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
    end else begin
      di = first_ready();
      fi = first_free();
      if (CDB_VALID && CDB_TAG != 0) begin
        for (int i = 0; i < DEPTH; i++) if (m_busy[i]) begin
          if (m_qj[i] == int'(CDB_TAG)) begin m_qj[i] = 0; m_vj[i] = CDB_DATA; end
          if (m_qk[i] == int'(CDB_TAG)) begin m_qk[i] = 0; m_vk[i] = CDB_DATA; end
        end
      end
      if (DISP_READY && di >= 0) m_busy[di] = 0;
      if (ISSUE_VALID && fi >= 0) begin
        qj = int'(ISSUE_QJ);
        qk = int'(ISSUE_QK);
        m_busy[fi] = 1;
        m_op[fi]   = ISSUE_OP;
        m_vj[fi]   = ISSUE_VJ;
        m_vk[fi]   = ISSUE_VK;
        if (CDB_VALID && qj != 0 && qj == int'(CDB_TAG)) begin qj = 0; m_vj[fi] = CDB_DATA; end
        if (CDB_VALID && qk != 0 && qk == int'(CDB_TAG)) begin qk = 0; m_vk[fi] = CDB_DATA; end
        m_qj[fi] = qj;
        m_qk[fi] = qk;
      end
    end
  endtask

  task automatic check_all(input string ph);
    int di, fi;
    di = first_ready();
    fi = first_free();
    chk({ph, ".issue_ready"}, 32'(ISSUE_READY), 32'(fi >= 0));
    chk({ph, ".issue_tag"},   32'(ISSUE_TAG),   32'(RS_BASE + ((fi >= 0) ? fi : 0)));
    chk({ph, ".disp_valid"},  32'(DISP_VALID),  32'(di >= 0));
    if (di >= 0) begin
      chk({ph, ".disp_op"},  32'(DISP_OP),  32'(m_op[di]));
      chk({ph, ".disp_a"},   DISP_A,        m_vj[di]);
      chk({ph, ".disp_b"},   DISP_B,        m_vk[di]);
      chk({ph, ".disp_tag"}, 32'(DISP_TAG), 32'(RS_BASE + di));
    end else begin
      chk({ph, ".disp_a_idle"},   DISP_A,        32'h0);
      chk({ph, ".disp_tag_idle"}, 32'(DISP_TAG), 32'(RS_BASE));
    end
  endtask

  task automatic tick(input string ph);
    @(posedge CLK);
    model_update();
    @(negedge CLK);
    check_all(ph);
  endtask

  task automatic idle();
    RST = 0; FLUSH = 0; ISSUE_VALID = 0; ISSUE_OP = 0; ISSUE_QJ = 0; ISSUE_QK = 0;
    ISSUE_VJ = 0; ISSUE_VK = 0; CDB_VALID = 0; CDB_TAG = 0; CDB_DATA = 0; DISP_READY = 0;
  endtask

  task automatic issue(input logic [1:0] op, input int qj, input int qk,
                       input logic [31:0] vj, input logic [31:0] vk);
    ISSUE_VALID = 1; ISSUE_OP = op; ISSUE_QJ = TAG_W'(qj); ISSUE_QK = TAG_W'(qk);
    ISSUE_VJ = vj; ISSUE_VK = vk;
  endtask

  function automatic logic [TAG_W-1:0] rnd_tag();
    if ($urandom_range(0, 2) == 0) return '0;
    return TAG_W'($urandom_range(1, 9));
  endfunction

  initial begin
    idle();
    RST = 1;
    @(negedge CLK);
    tick("rst");
    RST = 0;
    chk("rst.disp_valid",  32'(DISP_VALID),  32'h0);
    chk("rst.disp_op",     32'(DISP_OP),     32'h0);
    chk("rst.disp_b",      DISP_B,           32'h0);
    chk("rst.disp_tag",    32'(DISP_TAG),    32'h1);
    chk("rst.issue_ready", 32'(ISSUE_READY), 32'h1);
    chk("rst.issue_tag",   32'(ISSUE_TAG),   32'h1);

    // OR with both operands present dispatches the next cycle.
    issue(2'b01, 0, 0, 32'h0000_00F0, 32'h0000_000F);
    DISP_READY = 1;
    tick("or");
    ISSUE_VALID = 0;
    chk("or.valid", 32'(DISP_VALID), 32'h1);
    chk("or.op",    32'(DISP_OP),    32'h1);
    chk("or.a",     DISP_A,          32'h0000_00F0);
    chk("or.b",     DISP_B,          32'h0000_000F);
    chk("or.tag",   32'(DISP_TAG),   32'h1);
    tick("or_drain");
    chk("or.drained", 32'(DISP_VALID), 32'h0);

    // XOR waits on tag 5, then wakes from the CDB.
    DISP_READY = 0;
    issue(2'b10, 5, 0, 32'h0, 32'h0000_0003);
    tick("xor_iss");
    ISSUE_VALID = 0;
    chk("xor.waiting", 32'(DISP_VALID), 32'h0);
    CDB_VALID = 1; CDB_TAG = 5; CDB_DATA = 32'hDEAD_BEEF;
    tick("xor_wake");
    CDB_VALID = 0;
    chk("xor.valid", 32'(DISP_VALID), 32'h1);
    chk("xor.a",     DISP_A,          32'hDEAD_BEEF);
    DISP_READY = 1;
    tick("xor_drain");

    // Bypass: operand B's producer broadcasts in the issue cycle.
    DISP_READY = 0;
    issue(2'b00, 0, 7, 32'h5555_0000, 32'h0);
    CDB_VALID = 1; CDB_TAG = 7; CDB_DATA = 32'h0000_1234;
    tick("byp");
    ISSUE_VALID = 0; CDB_VALID = 0;
    chk("byp.valid", 32'(DISP_VALID), 32'h1);
    chk("byp.b",     DISP_B,          32'h0000_1234);
    DISP_READY = 1;
    tick("byp_drain");

    // Fill all entries, overflow issue is ignored, one dispatch frees tag 1.
    DISP_READY = 0;
    for (int i = 0; i < DEPTH; i++) begin
      issue(2'b11, 0, 0, 32'(i + 16), 32'(i));
      tick("fill");
    end
    chk("full.issue_ready", 32'(ISSUE_READY), 32'h0);
    issue(2'b01, 0, 0, 32'hBAD0_BAD0, 32'h0);
    tick("full_ignored");
    ISSUE_VALID = 0;
    chk("full.still", 32'(ISSUE_READY), 32'h0);
    DISP_READY = 1;
    tick("full_disp");
    DISP_READY = 0;
    chk("freed.issue_ready", 32'(ISSUE_READY), 32'h1);
    chk("freed.issue_tag",   32'(ISSUE_TAG),   32'h1);
    chk("freed.next_a",      DISP_A,           32'd17);
    // Issue and dispatch together: entry 0 is reloaded, entry 1 leaves.
    issue(2'b10, 0, 0, 32'hCAFE_0000, 32'h1);
    DISP_READY = 1;
    tick("iss_disp");
    ISSUE_VALID = 0; DISP_READY = 0;
    chk("iss_disp.issue_tag", 32'(ISSUE_TAG), 32'h2);
    chk("iss_disp.disp_a",    DISP_A,         32'hCAFE_0000);

    // FLUSH then RST mid-wait; a late CDB match must not resurrect anything.
    RST = 1;
    tick("pre_flush_rst");
    RST = 0;
    issue(2'b00, 6, 0, 32'h0, 32'h0);
    tick("w0");
    issue(2'b01, 0, 9, 32'h0, 32'h0);
    tick("w1");
    FLUSH = 1;
    issue(2'b01, 0, 0, 32'h1, 32'h1);
    tick("flush");
    FLUSH = 0;
    chk("flush.issue_tag", 32'(ISSUE_TAG), 32'h1);
    issue(2'b00, 6, 9, 32'h0, 32'h0);
    tick("w2");
    ISSUE_VALID = 0;
    RST = 1; FLUSH = 1; CDB_VALID = 1; CDB_TAG = 6; CDB_DATA = 32'h77;
    tick("rst_mid");
    RST = 0; FLUSH = 0;
    chk("rst_mid.disp_valid", 32'(DISP_VALID), 32'h0);
    chk("rst_mid.issue_tag",  32'(ISSUE_TAG),  32'h1);
    CDB_TAG = 9;
    tick("late_cdb6");
    tick("late_cdb9");
    CDB_VALID = 0;
    chk("late.disp_valid", 32'(DISP_VALID), 32'h0);

    // Random traffic, including CDB tags belonging to other stations.
    for (int c = 0; c < 3000; c++) begin
      RST         = ($urandom_range(0, 299) == 0);
      FLUSH       = ($urandom_range(0, 99) == 0);
      ISSUE_VALID = ($urandom_range(0, 1) == 1);
      ISSUE_OP    = 2'($urandom_range(0, 3));
      ISSUE_QJ    = rnd_tag();
      ISSUE_QK    = rnd_tag();
      ISSUE_VJ    = $urandom;
      ISSUE_VK    = $urandom;
      CDB_VALID   = ($urandom_range(0, 1) == 1);
      CDB_TAG     = TAG_W'($urandom_range(0, 9));
      CDB_DATA    = $urandom;
      DISP_READY  = ($urandom_range(0, 2) != 0);
      tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/logic_rs.md
LOGIC_RS -- requirements
Module: logic_rs

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of reservation-station entries (2..8).
REQ-002 SHALL have parameter TAG_W, default 4, width of producer tags; tag value 0 means "operand value present".
REQ-003 SHALL have parameter RS_BASE, default 1, tag of entry 0; entry i owns tag RS_BASE+i; RS_BASE+DEPTH-1 SHALL be < 2^TAG_W.
REQ-004 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-005 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-006 SHALL have port FLUSH  in  1  synchronous clear of all entries (mispredict recovery).
REQ-007 SHALL have port ISSUE_VALID  in  1  issue request from decode.
REQ-008 SHALL have port ISSUE_READY  out  1  at least one entry free.
REQ-009 SHALL have port ISSUE_OP  in  2  00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-010 SHALL have ports ISSUE_QJ, ISSUE_QK  in  TAG_W  producer tags of operands A and B.
REQ-011 SHALL have ports ISSUE_VJ, ISSUE_VK  in  32  operand values, meaningful when matching Q is 0.
REQ-012 SHALL have port ISSUE_TAG  out  TAG_W  tag of entry the issue will occupy (valid when ISSUE_READY).
REQ-013 SHALL have ports CDB_VALID in 1, CDB_TAG in TAG_W, CDB_DATA in 32  common-data-bus broadcast.
REQ-014 SHALL have port DISP_VALID  out  1  an entry is ready for the logic unit.
REQ-015 SHALL have port DISP_READY  in  1  logic unit accepts this cycle.
REQ-016 SHALL have ports DISP_OP out 2, DISP_A out 32, DISP_B out 32, DISP_TAG out TAG_W  dispatched op, operands, result tag.

Function
REQ-017 Each entry SHALL be in one of FREE, WAIT (≥1 operand tag nonzero), READY (both tags 0).
REQ-018 Issue handshake SHALL occur when ISSUE_VALID && ISSUE_READY at a rising edge; the lowest-index FREE entry SHALL be allocated.
REQ-019 ISSUE_READY SHALL be derived from registered state only (no combinational path from ISSUE_VALID or DISP_READY).
REQ-020 On issue, an operand whose Q equals CDB_TAG while CDB_VALID (and Q ≠ 0) SHALL capture CDB_DATA with Q cleared (same-cycle bypass).
REQ-021 Each cycle CDB_VALID with CDB_TAG ≠ 0 SHALL update every WAIT entry operand whose Q matches: V←CDB_DATA, Q←0; both operands may match in one cycle.
REQ-022 An entry SHALL transition WAIT→READY the cycle after its last operand is captured; FREE→READY directly if issued with both Q = 0.
REQ-023 DISP_VALID SHALL be 1 iff any entry is READY; DISP_* SHALL present the lowest-index READY entry, combinationally from entry registers.
REQ-024 Dispatch handshake (DISP_VALID && DISP_READY) SHALL return that entry to FREE at the edge; DISP_* SHALL hold stable while DISP_VALID && !DISP_READY unless a lower-index entry becomes READY.
REQ-025 Latency: issue with both operands ready at edge t → DISP_VALID high after edge t; CDB wakeup at edge t → dispatchable after edge t.
REQ-026 Full: with all entries non-FREE, ISSUE_READY SHALL be 0 and ISSUE_VALID SHALL be ignored; an entry freed by dispatch at edge t SHALL raise ISSUE_READY after edge t.
REQ-027 Issue and dispatch in the same cycle SHALL both take effect; the freed entry SHALL NOT be the one allocated that edge.
REQ-028 FLUSH SHALL free all entries at the edge, with priority over issue, CDB capture and dispatch.
REQ-029 CDB_TAG values outside RS_BASE..RS_BASE+DEPTH-1 SHALL still wake entries (other stations' producers).

Reset
REQ-030 While RST is high at an edge, all entries SHALL become FREE and all stored V/Q/op fields 0.
REQ-031 After reset: DISP_VALID=0, DISP_OP/A/B=0, DISP_TAG=RS_BASE, ISSUE_READY=1, ISSUE_TAG=RS_BASE.
REQ-032 RST SHALL have priority over FLUSH and all other inputs, including mid-operation with entries in WAIT.

Structure
REQ-033 A shared package SHALL hold the 2-bit op encodings, the entry-state enum (FREE/WAIT/READY), TAG_W default and the TAG_NONE=0 constant.
REQ-034 One sub-module, logic_rs_entry, SHALL hold a single entry's state, operand capture and CDB snoop; logic_rs SHALL instantiate DEPTH of them plus allocate/select priority logic.

Verification
REQ-035 Issue OR, QJ=QK=0, VJ=0x0000_00F0, VK=0x0000_000F, DISP_READY=1 → next cycle DISP_VALID=1, DISP_OP=01, DISP_A=0xF0, DISP_B=0x0F, DISP_TAG=1.
REQ-036 Issue XOR, QJ=5 → waits; CDB_VALID, tag 5, data 0xDEAD_BEEF → next cycle DISP_A=0xDEAD_BEEF, DISP_VALID=1.
REQ-037 Issue with QK=7 in same cycle as CDB tag 7 data 0x1234 → bypass captured, DISP_B=0x1234 next cycle.
REQ-038 Fill 4 entries with DISP_READY=0 → ISSUE_READY=0, 5th issue ignored; one dispatch → ISSUE_READY=1, ISSUE_TAG=freed tag.
REQ-039 Two entries in WAIT, assert FLUSH then RST mid-wait → all FREE, DISP_VALID=0, ISSUE_TAG=1, later CDB match produces no dispatch.
